// File: rtl/sev_disply_mux.sv
// Time-multiplexed seven-segment driver for an N-digit common-anode display.
// Scans one digit per slot, snapshots all inputs once per frame, and blanks the anodes at the start of each slot.
module sev_disply_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int HEX_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    lz_blank,
  output logic [7:0]              seg_cat,
  output logic [NUM_DIGITS-1:0]   seg_an,
  output logic                    frame_start
);

  localparam int TICKS = CLK_HZ / SCAN_HZ;
  localparam int PSC_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(TICKS - 1);
  localparam logic [PSC_W-1:0] BLANK_END = PSC_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state;
  logic [PSC_W-1:0]        psc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic                    snap_lz;

  logic [3:0]              cur_code;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    suppressed;
  logic                    visible;
  logic [7:0]              next_cat;
  logic [NUM_DIGITS-1:0]   next_an;

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'h0: seg_pattern = 7'h40;
      4'h1: seg_pattern = 7'h79;
      4'h2: seg_pattern = 7'h24;
      4'h3: seg_pattern = 7'h30;
      4'h4: seg_pattern = 7'h19;
      4'h5: seg_pattern = 7'h12;
      4'h6: seg_pattern = 7'h02;
      4'h7: seg_pattern = 7'h78;
      4'h8: seg_pattern = 7'h00;
      4'h9: seg_pattern = 7'h10;
      4'hA: seg_pattern = 7'h08;
      4'hB: seg_pattern = 7'h03;
      4'hC: seg_pattern = 7'h27;
      4'hD: seg_pattern = 7'h21;
      4'hE: seg_pattern = 7'h06;
      default: seg_pattern = 7'h0E;
    endcase
  endfunction

  // IDLE exists only for the first clock after reset, where the first snapshot is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      psc         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_lz     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (state == IDLE) begin
        state       <= SCAN;
        snap_digits <= digits;
        snap_dp     <= dp_en;
        snap_en     <= dig_en;
        snap_lz     <= lz_blank;
        frame_start <= 1'b1;
      end else if (psc == PSC_LAST) begin
        psc <= '0;
        if (idx == IDX_LAST) begin
          idx         <= '0;
          snap_digits <= digits;
          snap_dp     <= dp_en;
          snap_en     <= dig_en;
          snap_lz     <= lz_blank;
          frame_start <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        psc <= psc + 1'b1;
      end
    end
  end

  assign cur_code = snap_digits[4*idx +: 4];

  // upper_zero[i] is set when every digit from the leftmost down to i holds code 0.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (snap_digits[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  assign suppressed = snap_lz & (idx != '0) & upper_zero[idx];
  assign visible    = snap_en[idx] & ~suppressed & ((cur_code <= 4'd9) | (HEX_EN != 0));

  always_comb begin
    next_an  = '1;
    next_cat = 8'hFF;
    if ((psc >= BLANK_END) && visible) begin
      next_an[idx] = 1'b0;
      next_cat     = {~snap_dp[idx], seg_pattern(cur_code)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_cat <= 8'hFF;
      seg_an  <= '1;
    end else begin
      seg_cat <= next_cat;
      seg_an  <= next_an;
    end
  end

endmodule

// File: tb/tb_sev_disply_mux.sv
// Randomised and directed bench for sev_disply_mux, checked every cycle against a
// time-based behavioural model (slot and frame derived from the edge count since reset release).
module tb_sev_disply_mux;

  localparam int N     = 4;
  localparam int TICKS = 4;
  localparam int FRAME = TICKS * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_en = '0;
  logic [3:0]  dig_en = '0;
  logic        lz_blank = 1'b0;

  logic [7:0]  seg_cat, seg_cat_nh;
  logic [3:0]  seg_an, seg_an_nh;
  logic        frame_start, frame_start_nh;

  int checks = 0;
  int errors = 0;
  int k = 0;
  bit cmp_on = 1'b0;

  logic [15:0] fr_digits [256];
  logic [3:0]  fr_dp [256];
  logic [3:0]  fr_en [256];
  logic        fr_lz [256];

  logic [7:0] pat_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  sev_disply_mux #(.NUM_DIGITS(N), .CLK_HZ(16), .SCAN_HZ(4), .BLANK_CYC(1), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst(rst), .digits(digits), .dp_en(dp_en), .dig_en(dig_en),
    .lz_blank(lz_blank), .seg_cat(seg_cat), .seg_an(seg_an), .frame_start(frame_start)
  );

  sev_disply_mux #(.NUM_DIGITS(N), .CLK_HZ(16), .SCAN_HZ(4), .BLANK_CYC(1), .HEX_EN(0)) dut_nohex (
    .clk(clk), .rst(rst), .digits(digits), .dp_en(dp_en), .dig_en(dig_en),
    .lz_blank(lz_blank), .seg_cat(seg_cat_nh), .seg_an(seg_an_nh), .frame_start(frame_start_nh)
  );

  // k counts clock edges since reset release; every FRAME edges the inputs are recorded as that frame's snapshot.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if (k % FRAME == 0) begin
        fr_digits[(k / FRAME) % 256] <= digits;
        fr_dp[(k / FRAME) % 256]     <= dp_en;
        fr_en[(k / FRAME) % 256]     <= dig_en;
        fr_lz[(k / FRAME) % 256]     <= lz_blank;
      end
    end
  end

  function automatic logic [11:0] model_out(input bit hex, input logic [15:0] d, input logic [3:0] dp,
                                            input logic [3:0] en, input logic lz, input int slot, input int tick);
    int code;
    bit higher_zero;
    bit vis;
    logic [7:0] cat;
    logic [3:0] an;
    code = int'((d >> (4 * slot)) & 16'hF);
    higher_zero = 1'b1;
    for (int j = slot; j < N; j++)
      if (((d >> (4 * j)) & 16'hF) != 16'h0) higher_zero = 1'b0;
    vis = en[slot] && !(lz && slot != 0 && higher_zero) && (code < 10 || hex);
    if (tick < 1 || !vis) return {4'hF, 8'hFF};
    cat = pat_tab[code];
    if (dp[slot]) cat = cat - 8'h80;
    an = ~(4'(1) << slot);
    return {an, cat};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en, input logic lz);
    digits   = d;
    dp_en    = dp;
    dig_en   = en;
    lz_blank = lz;
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic atEdge(input int n);
    while (k < n) @(negedge clk);
  endtask

  logic [11:0] exp_hex, exp_nohex;
  bit          exp_fs;
  int          pos, frm;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      exp_hex   = {4'hF, 8'hFF};
      exp_nohex = {4'hF, 8'hFF};
      exp_fs    = 1'b0;
      if (!rst && k == 1) begin
        exp_fs = 1'b1;
      end else if (!rst && k >= 2) begin
        pos       = k - 2;
        frm       = (pos / FRAME) % 256;
        exp_hex   = model_out(1'b1, fr_digits[frm], fr_dp[frm], fr_en[frm], fr_lz[frm], (pos / TICKS) % N, pos % TICKS);
        exp_nohex = model_out(1'b0, fr_digits[frm], fr_dp[frm], fr_en[frm], fr_lz[frm], (pos / TICKS) % N, pos % TICKS);
        exp_fs    = ((k - 1) % FRAME == 0);
      end
      checkOutput("cmp_an", seg_an, exp_hex[11:8]);
      checkOutput("cmp_cat", seg_cat, exp_hex[7:0]);
      checkOutput("cmp_fs", frame_start, exp_fs);
      checkOutput("cmp_an_nohex", seg_an_nh, exp_nohex[11:8]);
      checkOutput("cmp_cat_nohex", seg_cat_nh, exp_nohex[7:0]);
      checkOutput("cmp_fs_nohex", frame_start_nh, exp_fs);
    end
  end

  initial begin
    cmp_on = 1'b1;
    $display("[TB] start");

    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("s1_rst_an", seg_an, 4'hF);
    checkOutput("s1_rst_cat", seg_cat, 8'hFF);
    checkOutput("s1_rst_fs", frame_start, 1'b0);
    rst = 1'b0;
    atEdge(1);  checkOutput("s1_fs_first", frame_start, 1'b1);
    atEdge(2);  checkOutput("s1_blank_an", seg_an, 4'hF);
    atEdge(3);  checkOutput("s1_slot0_an", seg_an, 4'hE);  checkOutput("s1_slot0_cat", seg_cat, 8'h99);
    atEdge(5);  checkOutput("s1_slot0_end", seg_cat, 8'h99);
    atEdge(7);  checkOutput("s1_slot1_an", seg_an, 4'hD);  checkOutput("s1_slot1_cat", seg_cat, 8'hB0);
    atEdge(11); checkOutput("s1_slot2_an", seg_an, 4'hB);  checkOutput("s1_slot2_cat", seg_cat, 8'hA4);
    atEdge(15); checkOutput("s1_slot3_an", seg_an, 4'h7);  checkOutput("s1_slot3_cat", seg_cat, 8'hF9);
    atEdge(16); checkOutput("s1_fs_low", frame_start, 1'b0);
    atEdge(17); checkOutput("s1_fs_frame", frame_start, 1'b1);

    applyStimulus(16'h0070, 4'h0, 4'hF, 1'b1);
    resetDut();
    atEdge(3);  checkOutput("s2_d0_cat", seg_cat, 8'hC0);
    atEdge(7);  checkOutput("s2_d1_cat", seg_cat, 8'hF8);
    atEdge(11); checkOutput("s2_d2_an", seg_an, 4'hF);
    atEdge(15); checkOutput("s2_d3_an", seg_an, 4'hF);
    applyStimulus(16'h0000, 4'h0, 4'hF, 1'b1);
    atEdge(19); checkOutput("s2_zero_d0", seg_cat, 8'hC0);
    atEdge(23); checkOutput("s2_zero_d1_an", seg_an, 4'hF);

    applyStimulus(16'hABEF, 4'h0, 4'hF, 1'b0);
    resetDut();
    atEdge(3);  checkOutput("s3_F", seg_cat, 8'h8E);  checkOutput("s3_nohex_an", seg_an_nh, 4'hF);
    atEdge(7);  checkOutput("s3_E", seg_cat, 8'h86);
    atEdge(11); checkOutput("s3_b", seg_cat, 8'h83);
    atEdge(15); checkOutput("s3_A", seg_cat, 8'h88);  checkOutput("s3_nohex_cat", seg_cat_nh, 8'hFF);

    applyStimulus(16'h5678, 4'b0100, 4'b1011, 1'b0);
    resetDut();
    atEdge(3);  checkOutput("s4_d0", seg_cat, 8'h80);
    atEdge(7);  checkOutput("s4_d1", seg_cat, 8'hF8);
    atEdge(11); checkOutput("s4_d2_an", seg_an, 4'hF);  checkOutput("s4_d2_cat", seg_cat, 8'hFF);
    atEdge(15); checkOutput("s4_d3", seg_cat, 8'h92);
    applyStimulus(16'h5678, 4'b0001, 4'b1011, 1'b0);
    atEdge(19); checkOutput("s4_dp_d0", seg_cat, 8'h00);

    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    resetDut();
    atEdge(10);
    applyStimulus(16'h9876, 4'h0, 4'hF, 1'b0);
    atEdge(15); checkOutput("s5_old_d3", seg_cat, 8'hF9);
    atEdge(19); checkOutput("s5_new_d0", seg_cat, 8'h82);
    atEdge(23); checkOutput("s5_new_d1", seg_cat, 8'hF8);

    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    resetDut();
    atEdge(11);
    #2 rst = 1'b1;
    #1;
    checkOutput("s6_async_an", seg_an, 4'hF);
    checkOutput("s6_async_cat", seg_cat, 8'hFF);
    checkOutput("s6_async_fs", frame_start, 1'b0);
    applyStimulus(16'h0009, 4'h0, 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    atEdge(1); checkOutput("s6_fs", frame_start, 1'b1);
    atEdge(3); checkOutput("s6_fresh_cat", seg_cat, 8'h90);  checkOutput("s6_fresh_an", seg_an, 4'hE);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] d;
        for (int n = 0; n < N; n++)
          d[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        applyStimulus(d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
